demux_router: RTL and testbench

- Registered 1-to-4 demultiplexer: the steering counterpart of the team's 4-to-1 select muxes.
- Takes one valid/ready input stream with a 2-bit destination select and delivers each beat to one of four independent valid/ready output channels.
- Each output channel has a one-entry register.
- Also provides a per-channel enable mask with drop reporting, and per-channel delivered-beat counters for debug/status.

---
 rtl/demux_router.sv | 117 +++++++++++
 tb/tb_demux_router.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// demux_router: registered 1-to-4 valid/ready steering demux with per-channel enable/drop and beat counters.
// Latency: 1 cycle from input accept to out_valid_o[sel]; drop_o pulses on the cycle after a dropped accept.
// Backpressure: in_ready_o is low only when the addressed, enabled channel is full and its out_ready_i is low.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_data_i/in_sel_i/in_valid_i input beat, destination channel, valid
//   in_ready_o                    input accepted when in_valid_i is also high
//   en_mask_i                     per-channel enable; disabled destinations drop the beat
//   out_data_o/out_valid_o        four packed channel payloads and valids
//   out_ready_i                   per-channel ready
//   drop_o                        one-cycle pulse after a beat was discarded
//   cnt_clr_i, beat_cnt_o         counter clear, four packed delivered-beat counters
module demux_router #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [1:0]          in_sel_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [3:0]          en_mask_i,
    output logic [4*DATA_W-1:0] out_data_o,
    output logic [3:0]          out_valid_o,
    input  logic [3:0]          out_ready_i,
    output logic                drop_o,
    input  logic                cnt_clr_i,
    output logic [4*CNT_W-1:0]  beat_cnt_o
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    ch_state_e           state_q [4];
    ch_state_e           state_d [4];
    logic [4*DATA_W-1:0] data_q, data_d;
    logic                drop_q, drop_d;
    logic [4*CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0] full;
    logic [3:0] hs;
    logic [3:0] load;
    logic       sel_en;
    logic       accept;

    always_comb begin
        full = '0;
        for (int k = 0; k < 4; k++) begin
            full[k] = (state_q[k] == CH_FULL);
        end
    end

    // A disabled destination is always ready so dropped beats never stall the input.
    // A full channel can still accept when it drains in the same cycle (1 beat/cycle).
    assign sel_en     = en_mask_i[in_sel_i];
    assign in_ready_o = !sel_en || !full[in_sel_i] || out_ready_i[in_sel_i];
    assign accept     = in_valid_i && in_ready_o;
    assign hs         = full & out_ready_i;

    always_comb begin
        load   = '0;
        data_d = data_q;
        drop_d = accept && !sel_en;
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            load[k]    = accept && sel_en && (in_sel_i == 2'(k));
            if (state_q[k] == CH_EMPTY) begin
                if (load[k]) state_d[k] = CH_FULL;
            end else begin
                // Handshake together with a reload keeps the channel full.
                if (hs[k] && !load[k]) state_d[k] = CH_EMPTY;
            end
            // Data only changes on a load, so it holds while stalled or empty.
            if (load[k]) data_d[k*DATA_W +: DATA_W] = in_data_i;
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (hs[k]) cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= CH_EMPTY;
            end
            data_q <= '0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
            end
            data_q <= data_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid_o = full;
    assign out_data_o  = data_q;
    assign drop_o      = drop_q;
    assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;
    localparam int DW = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      en_mask;
    logic [4*DW-1:0] out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic            drop;
    logic            cnt_clr;
    logic [4*CW-1:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: one FIFO of pending beats per channel, delivered counts, last drop flag.
    logic [DW-1:0] mq [4][$];
    int            mcnt [4];
    bit            mdrop;

    demux_router #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_sel_i    (in_sel),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .en_mask_i   (en_mask),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .drop_o      (drop),
        .cnt_clr_i   (cnt_clr),
        .beat_cnt_o  (beat_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ch_data(int k);
        return out_data[k*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] ch_cnt(int k);
        return beat_cnt[k*CW +: CW];
    endfunction

    function automatic bit exp_ready();
        return !en_mask[in_sel] || (mq[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
        mdrop = 1'b0;
    endfunction

    // Advance one clock: evaluate the rules on pre-edge inputs, then commit after the edge.
    task automatic tick();
        bit            acc, en, clr;
        bit [3:0]      hsv;
        logic [1:0]    s;
        logic [DW-1:0] d;
        s   = in_sel;
        en  = en_mask[s];
        d   = in_data;
        clr = cnt_clr;
        acc = in_valid && exp_ready();
        for (int k = 0; k < 4; k++) hsv[k] = (mq[k].size() > 0) && out_ready[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hsv[k]) void'(mq[k].pop_front());
            if (clr) mcnt[k] = 0;
            else if (hsv[k]) mcnt[k] = (mcnt[k] + 1) % (1 << CW);
        end
        if (acc && en) mq[s].push_back(d);
        mdrop = acc && !en;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = '0; in_sel = 2'd0; in_valid = 1'b0;
        en_mask = 4'hF; out_ready = 4'h0; cnt_clr = 1'b0;
        model_clear();
        #1;
        checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
        checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", beat_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        in_data = 8'hA5; in_sel = 2'd2; in_valid = 1'b1; en_mask = 4'hF; out_ready = 4'h0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_empty got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin failures++; $display("FAIL basic_valid got=%b exp=0100", out_valid); end
        checks++; if (ch_data(2) !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", ch_data(2)); end
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_full got=%b exp=0", in_ready); end
        in_sel = 2'd0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_other got=%b exp=1", in_ready); end
        out_ready = 4'b0100;
        tick();
        out_ready = 4'h0;
        checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL basic_drain got=%b exp=0000", out_valid); end
        checks++; if (ch_cnt(2) !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", ch_cnt(2)); end
        checks++; if (ch_data(2) !== 8'hA5) begin failures++; $display("FAIL basic_hold_invalid got=%h exp=a5", ch_data(2)); end
    endtask

    task automatic test_stream();
        out_ready = 4'b0010; in_sel = 2'd1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready beat=%0d got=%b exp=1", i, in_ready); end
            tick();
            checks++;
            if (out_valid[1] !== 1'b1 || ch_data(1) !== 8'(i)) begin
                failures++; $display("FAIL stream_data beat=%0d got=%b/%h exp=1/%h", i, out_valid[1], ch_data(1), 8'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 4'h0;
        checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL stream_empty got=%b exp=0000", out_valid); end
        checks++; if (ch_cnt(1) !== 8'd3) begin failures++; $display("FAIL stream_cnt got=%0d exp=3", ch_cnt(1)); end
    endtask

    task automatic test_drop();
        en_mask = 4'b1110; in_sel = 2'd0; in_data = 8'h55; in_valid = 1'b1; out_ready = 4'h0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; en_mask = 4'hF;
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", drop); end
        checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL drop_valid got=%b exp=0", out_valid[0]); end
        tick();
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%b exp=0", drop); end
        checks++; if (ch_cnt(0) !== 8'd0) begin failures++; $display("FAIL drop_cnt got=%0d exp=0", ch_cnt(0)); end
    endtask

    task automatic test_stall();
        out_ready = 4'h0; in_sel = 2'd3; in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_sel = 2'd0; in_data = 8'h88; out_ready = 4'b0001;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1001 || ch_data(0) !== 8'h88 || ch_data(3) !== 8'h77) begin
            failures++; $display("FAIL stall_both got=%b/%h/%h exp=1001/88/77", out_valid, ch_data(0), ch_data(3));
        end
        tick();
        checks++;
        if (out_valid !== 4'b1000 || ch_data(3) !== 8'h77) begin
            failures++; $display("FAIL stall_hold got=%b/%h exp=1000/77", out_valid, ch_data(3));
        end
        out_ready = 4'b1000;
        tick();
        checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL stall_release got=%b exp=0000", out_valid); end
        tick();
        out_ready = 4'h0;
        checks++; if (ch_cnt(3) !== 8'd1) begin failures++; $display("FAIL stall_once got=%0d exp=1", ch_cnt(3)); end
        checks++; if (ch_cnt(0) !== 8'd1) begin failures++; $display("FAIL stall_ch0_cnt got=%0d exp=1", ch_cnt(0)); end
    endtask

    task automatic test_wrap();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        out_ready = 4'b0001; in_sel = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (ch_cnt(0) !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", ch_cnt(0)); end
        tick();
        checks++; if (ch_cnt(0) !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", ch_cnt(0)); end
        // Put nonzero counts on several channels, then clear in a handshake cycle.
        out_ready = 4'h0; in_sel = 2'd1; in_valid = 1'b1;
        tick();
        out_ready = 4'b0110; in_sel = 2'd2; in_data = 8'h3C;
        tick();
        in_valid = 1'b0; out_ready = 4'h0;
        in_sel = 2'd1; in_valid = 1'b1; in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        checks++; if (beat_cnt === '0) begin failures++; $display("FAIL clr_precond got=%h exp=nonzero", beat_cnt); end
        out_ready = 4'b0110; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; out_ready = 4'h0;
        checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL clr_priority got=%h exp=0", beat_cnt); end
        checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL clr_drained got=%b exp=0000", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 4'h0; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        tick();
        in_sel = 2'd2; in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0110) begin failures++; $display("FAIL arst_precond got=%b exp=0110", out_valid); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL arst_valid got=%b exp=0000", out_valid); end
        checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL arst_cnt got=%h exp=0", beat_cnt); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL arst_drop got=%b exp=0", drop); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'hF;
        @(posedge clk);
        #1;
        tick();
        out_ready = 4'h0;
        checks++; if (out_valid !== 4'h0 || beat_cnt !== '0) begin
            failures++; $display("FAIL arst_nothing_after got=%b/%h exp=0000/0", out_valid, beat_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] ev;
        int         bad;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            en_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            out_ready = 4'($urandom);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready());
            end
            tick();
            ev = '0;
            for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
            checks++;
            if (out_valid !== ev) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, ev);
            end
            bad = 0;
            for (int k = 0; k < 4; k++) begin
                if (ev[k] && ch_data(k) !== mq[k][0]) bad++;
                if (ch_cnt(k) !== CW'(mcnt[k])) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++; $display("FAIL rnd_data_cnt cyc=%0d got=%h/%h exp_mismatches=0 seen=%0d", c, out_data, beat_cnt, bad);
            end
            checks++;
            if (drop !== mdrop) begin
                failures++; $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", c, drop, mdrop);
            end
        end
        in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 4'h0; en_mask = 4'hF;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_drop();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
